rgb2luma_stats: RTL and testbench
=================================

Name: rgb2luma_stats

Overview:
- Upstream neighbour of the histogram stage. Converts the 24-bit RGB pixel stream of the video receiver into 8-bit BT.601 luma (Y).
- Outputs y_o/dv_o/vs_o connect directly to the histogram block's y_i/dv_i/vs_i.
- Also collects per-frame statistics: active pixel count, min Y and max Y. These are latched at each frame boundary for sanity checking.
- Runs entirely in the receiver pixel-clock domain.

Parameters:
- COEF_R, 77, red weight (Q0.8)
- COEF_G, 150, green weight (Q0.8)
- COEF_B, 29, blue weight (Q0.8)
- CNT_BITS, 22, width of the per-frame pixel counter

Ports:
- clk  in  1  pixel clock; all logic on rising edge. One clock only. Reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high
- red_i  in  8  red component
- green_i  in  8  green component
- blue_i  in  8  blue component
- dv_i  in  1  pixel data valid
- hs_i  in  1  horizontal sync
- vs_i  in  1  vertical sync, active-high
- y_o  out  8  luma
- dv_o  out  1  dv_i delayed to match y_o
- hs_o  out  1  hs_i delayed to match y_o
- vs_o  out  1  vs_i delayed to match y_o
- frame_cnt_o  out  CNT_BITS  valid-pixel count of the last completed frame
- frame_min_o  out  8  minimum Y of the last completed frame
- frame_max_o  out  8  maximum Y of the last completed frame
- stats_valid_o  out  1  one-cycle pulse when the frame_* outputs update

Behaviour:
- Pipeline, fixed latency of 3 cycles from input to y_o/dv_o/hs_o/vs_o. Stages are registered every cycle, with no stall and no backpressure.
  - Stage 1: three 8x8 unsigned products, 16 bits each.
  - Stage 2: sum of the products, 18 bits.
  - Stage 3: add 128, shift right by 8, saturate to 255 if the result is above 255, register into y_o.
- Sync alignment: dv/hs/vs pass through a 3-deep shift register in lockstep with the data, so dv_o(t) = dv_i(t-3) and likewise for hs and vs.
- y_o is forced to 0 whenever dv_o=0. RGB inputs are ignored while dv_i=0.
- Frame boundary: the rising edge of vs_o, detected from a registered copy of vs_o.
- Accumulators are evaluated on the output side (dv_o, y_o):
  - cnt increments on each dv_o=1 cycle and saturates at all-ones (no wrap).
  - min/max update on each dv_o=1 cycle.
  - Accumulator init values: cnt=0, min=255, max=0.
- On a frame boundary with armed=1:
  - frame_cnt_o/frame_min_o/frame_max_o take the accumulator values, including a dv_o=1 pixel in that same cycle.
  - stats_valid_o=1 for exactly 1 cycle.
  - Accumulators re-init in the same cycle.
- Arming state machine, two states:
  - UNARMED to ARMED on the first vs_o rising edge after reset. That edge re-inits the accumulators but produces no stats_valid_o, because the partial frame is discarded.
  - ARMED persists until rst.
- Empty frame (no dv_o between boundaries) reports cnt=0, min=255, max=0 with stats_valid_o=1.
- Reset values, all asserted during and after rst:
  - y_o, dv_o, hs_o, vs_o = 0; pipeline registers = 0.
  - frame_cnt_o = 0, frame_min_o = 255, frame_max_o = 0, stats_valid_o = 0.
  - State UNARMED; accumulators at init values.
- Reset mid-frame: the pipeline is flushed with no spurious dv_o. The first post-reset vs edge only arms.
- vs_i held high for many cycles counts as one boundary (edge detect only).

Test Plan:
- Colour points, dv_i=1 → y_o exactly 3 cycles later:
  - RGB (255,255,255) → 255
  - RGB (255,0,0) → 77
  - RGB (0,255,0) → 149
  - RGB (0,0,255) → 29
  - RGB (0,0,0) → 0
- Sync alignment: random dv_i/hs_i/vs_i patterns with RGB=(200,200,200) → dv_o/hs_o/vs_o equal the inputs delayed 3 cycles; y_o=200 when dv_o=1, else 0.
- Arming: after rst, pulse vs_i, then 8 valid pixels with Y values {10,50,3,200,77,77,128,9}, then pulse vs_i.
  - First vs pulse → no stats_valid_o.
  - Second vs pulse → stats_valid_o single pulse at vs_o rise, with frame_cnt_o=8, frame_min_o=3, frame_max_o=200.
- Simultaneous event: with ARMED, drive a valid pixel Y=255 in the same cycle as the vs_i rising edge → that pixel is counted in the reported frame (max=255, count includes it), and the next frame starts at cnt=0.
- Empty frame: two vs pulses with no dv_i between them, while ARMED → stats_valid_o=1, cnt=0, min=255, max=0.
- Reset mid-frame: assert rst during an active line → all outputs hold reset values one cycle later, with no dv_o in the 3 cycles after release. The next vs edge produces no stats_valid_o; the following one does.

Source files
------------

// File: rtl/rgb2luma_stats.sv
// RGB to BT.601 luma, three-stage pipeline with delay-matched syncs,
// plus per-frame pixel count / min / max latched on each vs_o rising edge.
//
// state   | meaning
// UNARMED | waiting for the first frame boundary; the partial frame is discarded
// ARMED   | every frame boundary publishes the statistics
module rgb2luma_stats #(
  parameter int COEF_R   = 77,
  parameter int COEF_G   = 150,
  parameter int COEF_B   = 29,
  parameter int CNT_BITS = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          red_i,
  input  logic [7:0]          green_i,
  input  logic [7:0]          blue_i,
  input  logic                dv_i,
  input  logic                hs_i,
  input  logic                vs_i,
  output logic [7:0]          y_o,
  output logic                dv_o,
  output logic                hs_o,
  output logic                vs_o,
  output logic [CNT_BITS-1:0] frame_cnt_o,
  output logic [7:0]          frame_min_o,
  output logic [7:0]          frame_max_o,
  output logic                stats_valid_o
);

  localparam logic [15:0] CR = {8'd0, COEF_R[7:0]};
  localparam logic [15:0] CG = {8'd0, COEF_G[7:0]};
  localparam logic [15:0] CB = {8'd0, COEF_B[7:0]};

  typedef enum logic {UNARMED = 1'b0, ARMED = 1'b1} state_t;

  logic [15:0] prod_r_q, prod_g_q, prod_b_q;
  logic [17:0] sum_q;
  logic [17:0] rnd;
  logic [7:0]  y_q, y_d;
  logic [2:0]  sync1_q, sync2_q, sync3_q;
  logic        vs_prev_q;
  logic        boundary;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [7:0]            min_q, min_d, min_inc;
  logic [7:0]            max_q, max_d, max_inc;
  logic [CNT_BITS-1:0]   fcnt_q, fcnt_d;
  logic [7:0]            fmin_q, fmin_d, fmax_q, fmax_d;
  logic                  svalid_q, svalid_d;

  // Rounding adds half an LSB before the >>8; saturation only matters for
  // coefficient sets whose sum exceeds 256.
  assign rnd = sum_q + 18'd128;
  always_comb begin
    y_d = '0;
    if (sync2_q[2]) y_d = (|rnd[17:16]) ? 8'hFF : rnd[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      sum_q    <= '0;
      y_q      <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
    end else begin
      prod_r_q <= dv_i ? {8'd0, red_i}   * CR : '0;
      prod_g_q <= dv_i ? {8'd0, green_i} * CG : '0;
      prod_b_q <= dv_i ? {8'd0, blue_i}  * CB : '0;
      sum_q    <= {2'b00, prod_r_q} + {2'b00, prod_g_q} + {2'b00, prod_b_q};
      y_q      <= y_d;
      sync1_q  <= {dv_i, hs_i, vs_i};
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
    end
  end

  assign y_o  = y_q;
  assign dv_o = sync3_q[2];
  assign hs_o = sync3_q[1];
  assign vs_o = sync3_q[0];

  assign boundary = vs_o & ~vs_prev_q;
  assign cnt_inc  = (dv_o && cnt_q != '1) ? cnt_q + CNT_BITS'(1) : cnt_q;
  assign min_inc  = (dv_o && y_q < min_q) ? y_q : min_q;
  assign max_inc  = (dv_o && y_q > max_q) ? y_q : max_q;

  always_comb begin
    state_d  = state_q;
    svalid_d = 1'b0;
    fcnt_d   = fcnt_q;
    fmin_d   = fmin_q;
    fmax_d   = fmax_q;
    cnt_d    = cnt_inc;
    min_d    = min_inc;
    max_d    = max_inc;
    if (boundary) begin
      state_d = ARMED;
      cnt_d   = '0;
      min_d   = 8'hFF;
      max_d   = 8'h00;
      if (state_q == ARMED) begin
        svalid_d = 1'b1;
        fcnt_d   = cnt_inc;
        fmin_d   = min_inc;
        fmax_d   = max_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNARMED;
      vs_prev_q <= 1'b0;
      cnt_q     <= '0;
      min_q     <= 8'hFF;
      max_q     <= 8'h00;
      fcnt_q    <= '0;
      fmin_q    <= 8'hFF;
      fmax_q    <= 8'h00;
      svalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_prev_q <= vs_o;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      fcnt_q    <= fcnt_d;
      fmin_q    <= fmin_d;
      fmax_q    <= fmax_d;
      svalid_q  <= svalid_d;
    end
  end

  assign frame_cnt_o   = fcnt_q;
  assign frame_min_o   = fmin_q;
  assign frame_max_o   = fmax_q;
  assign stats_valid_o = svalid_q;

endmodule

// File: tb/tb_rgb2luma_stats.sv
// Directed bench for rgb2luma_stats: colour points, sync alignment, frame
// statistics, arming and mid-frame reset.
module tb_rgb2luma_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  red_i, green_i, blue_i;
  logic        dv_i, hs_i, vs_i;
  logic [7:0]  y_o;
  logic        dv_o, hs_o, vs_o;
  logic [21:0] frame_cnt_o;
  logic [7:0]  frame_min_o, frame_max_o;
  logic        stats_valid_o;

  int errors = 0;
  int checks = 0;
  int sv_cnt = 0;
  int sv_base;

  always #5 clk = ~clk;

  rgb2luma_stats dut (
    .clk(clk), .rst(rst),
    .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_o(y_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .frame_cnt_o(frame_cnt_o), .frame_min_o(frame_min_o),
    .frame_max_o(frame_max_o), .stats_valid_o(stats_valid_o)
  );

  always @(negedge clk) if (stats_valid_o) sv_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    red_i = r; green_i = g; blue_i = b; dv_i = 1'b1;
    tick();
    dv_i = 1'b0;
  endtask

  task automatic vs_pulse();
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int c, input int mn, input int mx);
    check({tag, "_cnt"}, 32'(frame_cnt_o), 32'(c));
    check({tag, "_min"}, 32'(frame_min_o), 32'(mn));
    check({tag, "_max"}, 32'(frame_max_o), 32'(mx));
  endtask

  logic [2:0] hist[$];
  logic [2:0] expv;
  logic [7:0] greys[8] = '{8'd10, 8'd50, 8'd3, 8'd200, 8'd77, 8'd77, 8'd128, 8'd9};
  logic [7:0] cr[5]    = '{8'd255, 8'd255, 8'd0,   8'd0,   8'd0};
  logic [7:0] cg[5]    = '{8'd255, 8'd0,   8'd255, 8'd0,   8'd0};
  logic [7:0] cb[5]    = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0};
  logic [7:0] cy[5]    = '{8'd255, 8'd77,  8'd149, 8'd29,  8'd0};

  initial begin
    rst = 1'b1; red_i = 0; green_i = 0; blue_i = 0;
    dv_i = 0; hs_i = 0; vs_i = 0;
    ticks(3);
    check("rst_y", 32'(y_o), 0);
    check("rst_dv", 32'(dv_o), 0);
    check("rst_vs", 32'(vs_o), 0);
    check_stats("rst", 0, 255, 0);
    check("rst_sv", 32'(stats_valid_o), 0);
    rst = 1'b0;

    // Colour points: still idle after 2 edges, value after exactly 3
    for (int k = 0; k < 5; k++) begin
      pix(cr[k], cg[k], cb[k]);
      tick();
      check("colour_early_dv", 32'(dv_o), 0);
      tick();
      check($sformatf("colour%0d_y", k), 32'(y_o), 32'(cy[k]));
      check("colour_dv", 32'(dv_o), 1);
      tick();
      check("colour_after_y", 32'(y_o), 0);
    end

    // Sync alignment with random dv/hs/vs
    hist.push_back(3'b000);
    hist.push_back(3'b000);
    red_i = 200; green_i = 200; blue_i = 200;
    for (int i = 0; i < 40; i++) begin
      dv_i = 1'($urandom_range(1)); hs_i = 1'($urandom_range(1)); vs_i = 1'($urandom_range(1));
      hist.push_back({dv_i, hs_i, vs_i});
      tick();
      expv = hist[hist.size()-3];
      check("sync_dv", 32'(dv_o), 32'(expv[2]));
      check("sync_hs", 32'(hs_o), 32'(expv[1]));
      check("sync_vs", 32'(vs_o), 32'(expv[0]));
      check("sync_y", 32'(y_o), expv[2] ? 32'd200 : 32'd0);
    end
    dv_i = 0; hs_i = 0; vs_i = 0;
    ticks(4);

    // Arming: first boundary only arms, second reports
    do_reset();
    sv_base = sv_cnt;
    vs_pulse();
    ticks(6);
    check("arm_first_no_sv", 32'(sv_cnt - sv_base), 0);
    for (int k = 0; k < 8; k++) pix(greys[k], greys[k], greys[k]);
    ticks(2);
    vs_pulse();
    ticks(6);
    check("arm_second_sv", 32'(sv_cnt - sv_base), 1);
    check_stats("arm", 8, 3, 200);

    // Pixel coincident with the vs rising edge belongs to the closing frame
    sv_base = sv_cnt;
    pix(8'd20, 8'd20, 8'd20);
    pix(8'd30, 8'd30, 8'd30);
    pix(8'd40, 8'd40, 8'd40);
    vs_i = 1'b1;
    pix(8'd255, 8'd255, 8'd255);
    vs_i = 1'b0;
    ticks(6);
    check("simul_sv", 32'(sv_cnt - sv_base), 1);
    check_stats("simul", 4, 20, 255);
    pix(8'd100, 8'd100, 8'd100);
    pix(8'd60, 8'd60, 8'd60);
    ticks(2);
    vs_pulse();
    ticks(6);
    check("next_frame_sv", 32'(sv_cnt - sv_base), 2);
    check_stats("next_frame", 2, 60, 100);

    // Empty frame; vs held high for several cycles is one boundary
    vs_i = 1'b1;
    ticks(5);
    vs_i = 1'b0;
    ticks(6);
    check("empty_sv", 32'(sv_cnt - sv_base), 3);
    check_stats("empty", 0, 255, 0);

    // Reset in the middle of an active line
    sv_base = sv_cnt;
    red_i = 90; green_i = 90; blue_i = 90; dv_i = 1'b1;
    ticks(5);
    rst = 1'b1;
    tick();
    check("midrst_dv", 32'(dv_o), 0);
    check("midrst_y", 32'(y_o), 0);
    check_stats("midrst", 0, 255, 0);
    rst = 1'b0; dv_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_flush_dv", 32'(dv_o), 0);
    end
    vs_pulse();
    ticks(6);
    check("midrst_arm_no_sv", 32'(sv_cnt - sv_base), 0);
    pix(8'd90, 8'd90, 8'd90);
    ticks(2);
    vs_pulse();
    ticks(6);
    check("midrst_report_sv", 32'(sv_cnt - sv_base), 1);
    check_stats("midrst_report", 1, 90, 90);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
